// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the canonical NOP encoding and the fetch bundle
// carried between the front-end stage registers.
package pipe_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned ILEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic                    valid;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN_DEFAULT-1:0] instr;
  } fetch_bundle_t;

endpackage

// File: rtl/skid_fifo.sv
// Small circular FIFO that absorbs fetch responses still in flight when decode stalls.
// The head entry is always visible; clear empties it in one edge.
module skid_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count alone,
  // which keeps the array as plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with stall/flush, skid buffering of late fetch
// responses, a registered trace tap and a saturating stall-cycle counter.
module if_id_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ILEN       = 32,
  parameter int unsigned SKID_DEPTH = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [ILEN-1:0]  in_instr,
  output logic             in_ready,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [ILEN-1:0]  id_instr,
  output logic             trace_valid,
  output logic [XLEN-1:0]  trace_pc,
  output logic [ILEN-1:0]  trace_instr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned     SK_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [ILEN-1:0] NOP      = ILEN'(NOP_INSTR);

  logic                 accept;
  logic                 advance;
  logic                 sk_push;
  logic                 sk_pop;
  logic                 sk_empty;
  logic                 sk_full;
  logic [SK_CNT_W-1:0]  sk_count;
  logic [XLEN+ILEN-1:0] sk_head;

  // in_ready depends only on the count register, never on stall.
  assign in_ready = rst_n && (sk_count < SK_CNT_W'(SKID_DEPTH));
  assign accept   = in_valid && in_ready && !flush;
  assign advance  = !stall || !id_valid;

  // Anything queued ahead forces the new input behind it to keep program order.
  assign sk_pop  = !flush && advance && !sk_empty;
  assign sk_push = accept && !sk_full && (!advance || !sk_empty);

  skid_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (sk_push),
    .pop   (sk_pop),
    .din   ({in_pc, in_instr}),
    .head  (sk_head),
    .count (sk_count),
    .empty (sk_empty),
    .full  (sk_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= NOP;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
    end else if (advance) begin
      if (!sk_empty) begin
        id_valid          <= 1'b1;
        {id_pc, id_instr} <= sk_head;
      end else if (accept) begin
        id_valid <= 1'b1;
        id_pc    <= in_pc;
        id_instr <= in_instr;
      end else begin
        id_valid <= 1'b0;
        id_instr <= NOP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_instr <= NOP;
    end else begin
      trace_valid <= in_valid && in_ready;
      trace_pc    <= in_pc;
      trace_instr <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && id_valid && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/if_id_pipe_reg.md
# if_id_pipe_reg

Parametrised IF/ID pipeline register that replaces the plain stall-hold instruction register between the fetch and decode stages. It carries PC and instruction with a valid bit, supports stall and flush, and absorbs in-flight fetch responses in a small skid FIFO. Without that FIFO, a synchronous instruction memory's one-cycle-late data would be lost when decode stalls. It also provides a registered trace port and a stall-cycle performance counter.

## Interface
Parameters:
- XLEN, 32, PC width
- ILEN, 32, instruction width
- SKID_DEPTH, 2, skid FIFO entries (≥1; power of two not required)
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  decode cannot accept; output register holds
- flush  in  1  discard all held/incoming instructions (branch redirect)
- in_valid  in  1  fetch presents pc/instr this cycle
- in_pc  in  XLEN  fetch PC
- in_instr  in  ILEN  fetch instruction
- in_ready  out  1  register can accept; = (skid count < SKID_DEPTH) && rst_n
- id_valid  out  1  id_pc/id_instr hold a live instruction
- id_pc  out  XLEN  decode-stage PC
- id_instr  out  ILEN  decode-stage instruction; NOP when !id_valid
- trace_valid  out  1  registered copy of in_valid && in_ready
- trace_pc  out  XLEN  registered in_pc
- trace_instr  out  ILEN  registered in_instr
- stall_cnt  out  CNT_W  cycles with stall && id_valid

## Operation
- Accept: in_valid && in_ready && !flush.
- Advance: !stall || !id_valid. The output register is empty or being consumed.
- When advance is true, the output loads the skid head if the skid is non-empty. Otherwise it loads the accepted input. Otherwise it becomes empty: id_valid=0, id_instr=NOP, id_pc unchanged.
- An accepted input goes to the skid tail if !advance, or if the skid is non-empty. Otherwise it goes straight to the output.
- Simultaneous skid pop and push is legal; the count is unchanged.
- Strict program order is kept: output, then skid head, then tail.
- The skid never overflows, because in_ready is low when count == SKID_DEPTH. Pushing when full is a design error; the bench asserts against it.
- Flush has priority over everything:
  - id_valid←0 and id_instr←NOP.
  - Skid count←0 and pointers←0.
  - Input in the same cycle is dropped.
  - stall is ignored that cycle.
- Pointers wrap modulo SKID_DEPTH.
- Trace: every cycle, trace_* ← in_* and trace_valid ← in_valid && in_ready. This is independent of stall and flush.
- stall_cnt increments when stall && id_valid. It saturates at all-ones and clears only on reset.

## Timing
- Reset (rst_n=0 at a clk edge):
  - id_valid=0, id_pc=0, id_instr=NOP (32'h00000013).
  - Skid count=0.
  - trace_valid=0, trace_pc=0, trace_instr=NOP.
  - stall_cnt=0.
  - in_ready=0 while rst_n is low.
- Latency in-to-id: 1 cycle with the skid empty and no stall. Otherwise 1 + (skid entries ahead) cycles after stall drops.
- Throughput: 1 instruction/cycle sustained.
- in_ready is combinational from the count register only. It has no path from stall.
- An edge where stall rises with SKID_DEPTH responses in flight loses nothing.
- Reset mid-operation discards all contents on that edge. in_ready rises in the first cycle after rst_n returns high.
- Flush takes effect on the same edge. The next cycle's input is accepted normally.

## Structure
- Shared package pipe_pkg holds:
  - NOP_INSTR = 32'h00000013
  - the fetch-bundle struct {valid, pc, instr}, for reuse by the ID/EX and later registers
- Sub-module skid_fifo:
  - parametrised width/depth
  - push/pop/clear inputs; count/empty/full outputs
  - head readable without pop
- Top level holds the output register, the advance/flush control, trace and the counter.

## Test plan
- Streaming: PCs 0x0,0x4,0x8 with no stall → id_pc 0x0,0x4,0x8 on consecutive cycles, one cycle after each input; in_ready stays 1.
- Stall absorb, SKID_DEPTH=2: stall at 0x10 while 0x14,0x18 arrive.
  - Expected: in_ready=0 after 2 pushes; id holds 0x10.
  - After stall drops: 0x14 then 0x18, no loss or duplication.
- Flush with full skid plus input 0x40 same cycle: next cycle id_valid=0, id_instr=0x00000013, in_ready=1; 0x40 never appears.
- Reset mid-stall with 2 skid entries: all outputs at reset values; trace_valid=0; stall_cnt=0.
- Counter: 5 stall cycles with id_valid=1 and 3 with id_valid=0 → stall_cnt=5. With CNT_W=3, 10 stall cycles → saturates at 7.
- Trace: stall held, input 0x20/0x00A00093 accepted → trace_pc=0x20 and trace_instr=0x00A00093 next cycle, while id_* is unchanged.
